lfsr_scan_display: RTL and testbench



---
 rtl/lfsr_scan_display_if.sv | 27 ++
 rtl/lfsr_scan_display.sv | 122 ++++++++++++
 tb/tb_lfsr_scan_display.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_scan_display_if.sv
// rtl/lfsr_scan_display_if.sv - control/status bundle for the LFSR scan display
// master drives control and seed; slave (the LFSR block) drives state and display.
interface lfsr_scan_display_if #(
  parameter int WIDTH = 8,
  parameter int NDIG  = (WIDTH + 3) / 4
);
  logic             en;
  logic             mode;
  logic             step;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] state;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic [6:0]       seg;
  logic [NDIG-1:0]  dig_an;

  modport master (
    output en, mode, step, load, seed,
    input  state, wrap, period, seg, dig_an
  );

  modport slave (
    input  en, mode, step, load, seed,
    output state, wrap, period, seg, dig_an
  );
endinterface

// File: rtl/lfsr_scan_display.sv
// rtl/lfsr_scan_display.sv - XNOR Fibonacci LFSR with period measurement and hex scan display
// Step input is synchronised and edge-detected; load beats lock-up recovery beats advance.
module lfsr_scan_display #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
  parameter int               SCAN_DIV = 1024,
  parameter int               NDIG     = (WIDTH + 3) / 4
) (
  input  logic clk,
  input  logic rst_n,
  lfsr_scan_display_if.slave bus
);

  localparam int               IW        = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int               PW        = NDIG * 4;
  localparam logic [WIDTH-1:0] ONES      = '1;
  localparam logic [15:0]      SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(NDIG - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [WIDTH-1:0] state_q, state_d, start_q, start_d, count_q, count_d, period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [15:0]      scan_q, scan_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [NDIG-1:0]  dig_an_q, dig_an_d;

  logic             fb, pulse, adv;
  logic [WIDTH-1:0] lfsr_next, adv_next, load_val;
  logic [PW-1:0]    padded;

  always_comb begin
    s1_d = bus.step;
    s2_d = s1_q;
    s3_d = s2_q;
    pulse = s2_q & ~s3_q;
    // In single-step mode a pulse seen while en=0 is simply lost, never queued.
    adv = bus.en & (bus.mode ? pulse : 1'b1);

    fb        = ~^(state_q & TAPS);
    lfsr_next = {state_q[WIDTH-2:0], fb};
    adv_next  = (state_q == ONES) ? '0 : lfsr_next;
    load_val  = (bus.seed == ONES) ? '0 : bus.seed;

    state_d  = state_q;
    start_d  = start_q;
    count_d  = count_q;
    period_d = period_q;
    wrap_d   = 1'b0;

    if (bus.load) begin
      state_d = load_val;
      start_d = load_val;
      count_d = '0;
    end else if (adv) begin
      state_d = adv_next;
      if (adv_next == start_q) begin
        // A saturated count cannot express the true period, so keep the old one.
        if (count_q != ONES) period_d = count_q + 1'b1;
        count_d = '0;
        wrap_d  = 1'b1;
      end else if (count_q != ONES) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? 16'd0 : scan_q + 16'd1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    padded   = PW'(state_q);
    seg_d    = hex7(padded[int'(idx_d) * 4 +: 4]);
    dig_an_d = NDIG'(1) << idx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      start_q  <= '0;
      count_q  <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      scan_q   <= 16'd0;
      idx_q    <= '0;
      seg_q    <= 7'h3F;
      dig_an_q <= NDIG'(1);
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      count_q  <= count_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_an_q <= dig_an_d;
    end
  end

  assign bus.state  = state_q;
  assign bus.wrap   = wrap_q;
  assign bus.period = period_q;
  assign bus.seg    = seg_q;
  assign bus.dig_an = dig_an_q;

endmodule

// File: tb/tb_lfsr_scan_display.sv
// tb/tb_lfsr_scan_display.sv - directed bench for lfsr_scan_display
// Three instances: 4-bit taps C (sequence/load/step/reset), 4-bit taps D (lock-up), 8-bit (display).
module tb_lfsr_scan_display;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc;

  lfsr_scan_display_if #(.WIDTH(4)) if_a ();
  lfsr_scan_display_if #(.WIDTH(4)) if_b ();
  lfsr_scan_display_if #(.WIDTH(8)) if_c ();

  lfsr_scan_display #(.WIDTH(4), .TAPS(4'hC), .SCAN_DIV(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  lfsr_scan_display #(.WIDTH(4), .TAPS(4'hD), .SCAN_DIV(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  lfsr_scan_display #(.WIDTH(8), .TAPS(8'hB8), .SCAN_DIV(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic       en;
    logic       load;
    logic [3:0] seed;
    logic [3:0] st;
    logic       wrap;
    logic [3:0] per;
  } vec_t;

  vec_t       tv [38];
  logic [3:0] seq   [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                             4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
  logic [3:0] seq_b [7]  = '{4'h1, 4'h2, 4'h5, 4'hB, 4'h7, 4'hF, 4'h0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_row(input vec_t v);
    tv[0] = tv[0];
    if_a.en   = v.en;
    if_a.load = v.load;
    if_a.seed = v.seed;
  endtask

  initial begin
    for (int i = 0; i < 30; i++) begin
      tv[i].en   = 1'b1;
      tv[i].load = 1'b0;
      tv[i].seed = 4'h0;
      tv[i].st   = seq[i % 15];
      tv[i].wrap = ((i % 15) == 14);
      tv[i].per  = (i >= 14) ? 4'd15 : 4'd0;
    end
    tv[30] = '{en: 1'b1, load: 1'b1, seed: 4'h7, st: 4'h7, wrap: 1'b0, per: 4'd15};
    tv[31] = '{en: 1'b1, load: 1'b0, seed: 4'h0, st: 4'hE, wrap: 1'b0, per: 4'd15};
    tv[32] = '{en: 1'b1, load: 1'b0, seed: 4'h0, st: 4'hD, wrap: 1'b0, per: 4'd15};
    tv[33] = '{en: 1'b1, load: 1'b1, seed: 4'hF, st: 4'h0, wrap: 1'b0, per: 4'd15};
    tv[34] = '{en: 1'b0, load: 1'b0, seed: 4'h0, st: 4'h0, wrap: 1'b0, per: 4'd15};
    tv[35] = '{en: 1'b0, load: 1'b0, seed: 4'h0, st: 4'h0, wrap: 1'b0, per: 4'd15};
    tv[36] = '{en: 1'b1, load: 1'b0, seed: 4'h0, st: 4'h1, wrap: 1'b0, per: 4'd15};
    tv[37] = '{en: 1'b1, load: 1'b0, seed: 4'h0, st: 4'h3, wrap: 1'b0, per: 4'd15};

    if_a.en = 1'b1; if_a.mode = 1'b0; if_a.step = 1'b0; if_a.load = 1'b0; if_a.seed = '0;
    if_b.en = 1'b0; if_b.mode = 1'b0; if_b.step = 1'b0; if_b.load = 1'b0; if_b.seed = '0;
    if_c.en = 1'b0; if_c.mode = 1'b0; if_c.step = 1'b0; if_c.load = 1'b0; if_c.seed = '0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_state",  32'(if_a.state),  32'h0);
    chk("reset_wrap",   32'(if_a.wrap),   32'h0);
    chk("reset_period", 32'(if_a.period), 32'h0);
    chk("reset_seg",    32'(if_a.seg),    32'h3F);
    chk("reset_dig_an", 32'(if_c.dig_an), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-run laps, seed loads and en hold, one table row per clock.
    for (int i = 0; i < 38; i++) begin
      set_row(tv[i]);
      cyc1();
      chk($sformatf("row%0d_state", i),  32'(if_a.state),  32'(tv[i].st));
      chk($sformatf("row%0d_wrap", i),   32'(if_a.wrap),   32'(tv[i].wrap));
      chk($sformatf("row%0d_period", i), 32'(if_a.period), 32'(tv[i].per));
    end
    if_a.load = 1'b0;

    // Single step: held-high step gives one advance on the third edge.
    if_a.mode = 1'b1; if_a.load = 1'b1; if_a.seed = 4'h0;
    cyc1();
    if_a.load = 1'b0;
    chk("step_preload", 32'(if_a.state), 32'h0);
    if_a.step = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc1();
      chk($sformatf("step_hold%0d", k), 32'(if_a.state), (k >= 3) ? 32'h1 : 32'h0);
      chk($sformatf("step_wrap%0d", k), 32'(if_a.wrap), 32'h0);
    end
    if_a.step = 1'b0;
    repeat (3) cyc1();
    if_a.step = 1'b1;
    repeat (3) cyc1();
    chk("step_second", 32'(if_a.state), 32'h3);

    // Load coincident with a live step pulse: load wins, pulse discarded.
    if_a.step = 1'b0;
    repeat (3) cyc1();
    if_a.step = 1'b1;
    repeat (2) cyc1();
    chk("pulse_pending", 32'(if_a.state), 32'h3);
    if_a.load = 1'b1; if_a.seed = 4'h9;
    cyc1();
    chk("load_vs_step", 32'(if_a.state), 32'h9);
    if_a.load = 1'b0;
    repeat (3) cyc1();
    chk("load_vs_step_after", 32'(if_a.state), 32'h9);

    // Step edge arriving while en=0 is dropped.
    if_a.step = 1'b0;
    repeat (3) cyc1();
    if_a.en = 1'b0; if_a.step = 1'b1;
    repeat (4) cyc1();
    if_a.en = 1'b1;
    repeat (3) cyc1();
    chk("step_dropped_en0", 32'(if_a.state), 32'h9);
    if_a.en = 1'b0; if_a.step = 1'b0; if_a.mode = 1'b0;

    // Lock-up recovery: taps D walks into all-ones, next advance forces zero.
    if_b.en = 1'b1; if_b.load = 1'b1; if_b.seed = 4'h0;
    cyc1();
    if_b.load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc1();
      chk($sformatf("lockup_state%0d", i), 32'(if_b.state), 32'(seq_b[i]));
      chk($sformatf("lockup_wrap%0d", i),  32'(if_b.wrap),  (i == 6) ? 32'h1 : 32'h0);
    end
    chk("lockup_period", 32'(if_b.period), 32'd7);
    if_b.en = 1'b0;

    // Display scan of 8'hA5, state frozen.
    if_c.en = 1'b1; if_c.load = 1'b1; if_c.seed = 8'hA5;
    cyc1();
    if_c.load = 1'b0; if_c.en = 1'b0;
    repeat (2) cyc1();
    chk("disp_state", 32'(if_c.state), 32'hA5);
    for (int k = 0; k < 16; k++) begin
      cyc1();
      chk($sformatf("disp_an%0d", k),  32'(if_c.dig_an), (((cyc / 4) % 2) == 1) ? 32'h2 : 32'h1);
      chk($sformatf("disp_seg%0d", k), 32'(if_c.seg),    (((cyc / 4) % 2) == 1) ? 32'h77 : 32'h6D);
    end

    // Asynchronous reset between edges, then restart of the sequence.
    if_a.en = 1'b1;
    repeat (3) cyc1();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state",  32'(if_a.state),  32'h0);
    chk("arst_period", 32'(if_a.period), 32'h0);
    chk("arst_wrap",   32'(if_a.wrap),   32'h0);
    chk("arst_seg",    32'(if_a.seg),    32'h3F);
    chk("arst_seg_c",  32'(if_c.seg),    32'h3F);
    chk("arst_an_c",   32'(if_c.dig_an), 32'h1);
    #1 rst_n = 1'b1;
    cyc1();
    chk("arst_restart1", 32'(if_a.state), 32'h1);
    cyc1();
    chk("arst_restart2", 32'(if_a.state), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
